id_ex_operand_stage: RTL

//  ID/EX pipeline register plus EX-side operand front-end for the pipelined CPU.

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/forward_unit.sv | 30 +++
 rtl/id_ex_operand_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register aliases, ALU opcodes, forwarding
// selectors and the packed ID/EX latch layout.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    aluop_t   aluop;
    regbits_t rs;
    regbits_t rt;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    logic     alusrc;
    logic     shift;
    regbits_t wsel;
    logic     regwen;
    logic     memread;
  } id_ex_t;

endpackage

// File: rtl/forward_unit.sv
// Per-operand forwarding decision: the youngest in-flight writer of the source
// register wins; register $0 is never forwarded.
module forward_unit
  import cpu_types_pkg::*;
(
  input  regbits_t src_reg_i,
  input  logic     exmem_regwen_i,
  input  regbits_t exmem_wsel_i,
  input  word_t    exmem_wdat_i,
  input  logic     memwb_regwen_i,
  input  regbits_t memwb_wsel_i,
  input  word_t    memwb_wdat_i,
  output fwd_sel_t sel_o,
  output word_t    data_o
);

  // data_o carries the winning source's value; meaningless when sel_o is FWD_NONE.
  always_comb begin
    sel_o  = FWD_NONE;
    data_o = memwb_wdat_i;
    if (exmem_regwen_i && (exmem_wsel_i != '0) && (exmem_wsel_i == src_reg_i)) begin
      sel_o  = FWD_EXMEM;
      data_o = exmem_wdat_i;
    end else if (memwb_regwen_i && (memwb_wsel_i != '0) && (memwb_wsel_i == src_reg_i)) begin
      sel_o  = FWD_MEMWB;
      data_o = memwb_wdat_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, immediate/shift
// muxing into the ALU ports, and single-bubble load-use hazard detection.
module id_ex_operand_stage
  import cpu_types_pkg::*;
#(
  parameter int NREG = 32,
  parameter int WORD = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     id_valid,
  input  aluop_t                   id_aluop,
  input  logic [$clog2(NREG)-1:0]  id_rs,
  input  logic [$clog2(NREG)-1:0]  id_rt,
  input  logic [WORD-1:0]          id_rdat1,
  input  logic [WORD-1:0]          id_rdat2,
  input  logic [WORD-1:0]          id_imm,
  input  logic                     id_alusrc,
  input  logic                     id_shift,
  input  logic                     id_uses_rt,
  input  logic [$clog2(NREG)-1:0]  id_wsel,
  input  logic                     id_regwen,
  input  logic                     id_memread,
  input  logic                     exmem_regwen,
  input  logic [$clog2(NREG)-1:0]  exmem_wsel,
  input  logic [WORD-1:0]          exmem_wdat,
  input  logic                     memwb_regwen,
  input  logic [$clog2(NREG)-1:0]  memwb_wsel,
  input  logic [WORD-1:0]          memwb_wdat,
  input  logic                     ex_stall,
  input  logic                     flush,
  output logic                     hazard_stall,
  output aluop_t                   ALUOP,
  output logic [WORD-1:0]          PortA,
  output logic [WORD-1:0]          PortB,
  output logic [WORD-1:0]          ex_storedat,
  output logic                     ex_valid,
  output logic [$clog2(NREG)-1:0]  ex_wsel,
  output logic                     ex_regwen,
  output logic                     ex_memread
);

  id_ex_t   ex_q, ex_d;
  fwd_sel_t sel_a, sel_b;
  word_t    src_a, src_b;
  word_t    fwd_a, fwd_b;
  logic     load_use;

  assign load_use = ex_q.valid & ex_q.memread & (ex_q.wsel != '0) & id_valid &
                    ((ex_q.wsel == id_rs) | (id_uses_rt & (ex_q.wsel == id_rt)));
  // A frozen or squashed ID instruction cannot be the victim of a load-use.
  assign hazard_stall = load_use & ~ex_stall & ~flush;

  always_comb begin
    ex_d = '{valid:   id_valid,
             aluop:   id_aluop,
             rs:      id_rs,
             rt:      id_rt,
             rdat1:   id_rdat1,
             rdat2:   id_rdat2,
             imm:     id_imm,
             alusrc:  id_alusrc,
             shift:   id_shift,
             wsel:    id_wsel,
             regwen:  id_regwen,
             memread: id_memread};
    if (flush || hazard_stall) begin
      ex_d.valid   = 1'b0;
      ex_d.regwen  = 1'b0;
      ex_d.memread = 1'b0;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q <= '0;
    end else if (!ex_stall) begin
      ex_q <= ex_d;
    end
  end

  forward_unit u_fwd_a (
    .src_reg_i      (ex_q.rs),
    .exmem_regwen_i (exmem_regwen),
    .exmem_wsel_i   (exmem_wsel),
    .exmem_wdat_i   (exmem_wdat),
    .memwb_regwen_i (memwb_regwen),
    .memwb_wsel_i   (memwb_wsel),
    .memwb_wdat_i   (memwb_wdat),
    .sel_o          (sel_a),
    .data_o         (src_a)
  );

  forward_unit u_fwd_b (
    .src_reg_i      (ex_q.rt),
    .exmem_regwen_i (exmem_regwen),
    .exmem_wsel_i   (exmem_wsel),
    .exmem_wdat_i   (exmem_wdat),
    .memwb_regwen_i (memwb_regwen),
    .memwb_wsel_i   (memwb_wsel),
    .memwb_wdat_i   (memwb_wdat),
    .sel_o          (sel_b),
    .data_o         (src_b)
  );

  assign fwd_a = (sel_a == FWD_NONE) ? ex_q.rdat1 : src_a;
  assign fwd_b = (sel_b == FWD_NONE) ? ex_q.rdat2 : src_b;

  assign ALUOP       = ex_q.aluop;
  assign PortA       = ex_q.shift ? fwd_b : fwd_a;
  assign PortB       = (ex_q.alusrc || ex_q.shift) ? ex_q.imm : fwd_b;
  assign ex_storedat = fwd_b;
  assign ex_valid    = ex_q.valid;
  assign ex_wsel     = ex_q.wsel;
  assign ex_regwen   = ex_q.regwen & ex_q.valid;
  assign ex_memread  = ex_q.memread & ex_q.valid;

endmodule
